// File: rtl/regfile_writeback_if.sv
// Bundle of ALU result, load issue/return, writeback and decode-lookup signals
// around the register-bank writer. "master" is the core side, "slave" is the writer.
interface regfile_writeback_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_result;

    logic            ld_issue_valid;
    logic [4:0]      ld_issue_rd;

    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;

    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_pending;
    logic            rs2_pending;

    modport master (
        output alu_valid, alu_rd, alu_result,
        output ld_issue_valid, ld_issue_rd,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  wb_addr, wb_data, wb_en,
        output rs1_addr, rs2_addr,
        input  rs1_pending, rs2_pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_result,
        input  ld_issue_valid, ld_issue_rd,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output wb_addr, wb_data, wb_en,
        input  rs1_addr, rs2_addr,
        output rs1_pending, rs2_pending
    );
endinterface

// File: rtl/regfile_writeback.sv
// Single write-port arbiter for the 32x32 register bank: ALU results win, load
// returns are queued in a small FIFO, and a pending-load scoreboard feeds decode.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_writeback_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Load-return FIFO storage and control
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    // Writeback register and source tracking
    logic            wb_en_q,      wb_en_d;
    logic            wb_is_load_q, wb_is_load_d;
    logic [4:0]      wb_addr_q,    wb_addr_d;
    logic [XLEN-1:0] wb_data_q,    wb_data_d;

    logic [31:0]     sb_q, sb_d;

    logic            mem_ready;
    logic            alu_sel;
    logic            push;
    logic            pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    // mem_ready depends only on registered occupancy, never on this cycle's inputs.
    assign mem_ready = (count_q < DEPTH_C);
    assign head_rd   = fifo_rd_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        alu_sel  = bus.alu_valid && (bus.alu_rd != 5'd0);
        push     = bus.mem_valid && mem_ready && (bus.mem_rd != 5'd0);
        pop      = !alu_sel && (count_q != '0);

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        wb_en_d      = 1'b0;
        wb_is_load_d = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        if (alu_sel) begin
            wb_en_d   = 1'b1;
            wb_addr_d = bus.alu_rd;
            wb_data_d = bus.alu_result;
        end else if (pop) begin
            wb_en_d      = 1'b1;
            wb_is_load_d = 1'b1;
            wb_addr_d    = head_rd;
            wb_data_d    = head_data;
        end
    end

    // Clear lands on the same edge the bank commits the load; a new issue to the
    // same register on that edge overrides the clear.
    always_comb begin
        sb_d = sb_q;
        if (wb_en_q && wb_is_load_q) begin
            sb_d[wb_addr_q] = 1'b0;
        end
        if (bus.ld_issue_valid && (bus.ld_issue_rd != 5'd0)) begin
            sb_d[bus.ld_issue_rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wb_en_q      <= 1'b0;
            wb_is_load_q <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            sb_q         <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wb_en_q      <= wb_en_d;
            wb_is_load_q <= wb_is_load_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            sb_q         <= sb_d;
        end
    end

    // Storage is qualified by the pointers/count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.mem_data;
            fifo_rd_q[wr_ptr_q]   <= bus.mem_rd;
        end
    end

    assign bus.mem_ready   = mem_ready;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.rs1_pending = sb_q[bus.rs1_addr];
    assign bus.rs2_pending = sb_q[bus.rs2_addr];

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU path, load path with scoreboard,
// arbitration, FIFO full behaviour, set/clear collision and async reset.
module tb_regfile_writeback;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    regfile_writeback_if #(.XLEN(32)) bus ();

    regfile_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid      = 1'b0;
        bus.alu_rd         = 5'd0;
        bus.alu_result     = 32'd0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_rd    = 5'd0;
        bus.mem_valid      = 1'b0;
        bus.mem_rd         = 5'd0;
        bus.mem_data       = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.ld_issue_valid = 1'b1;
        bus.ld_issue_rd    = rd;
        tick();
        bus.ld_issue_valid = 1'b0;
        bus.ld_issue_rd    = 5'd0;
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] addr, input logic [31:0] data);
        chk({tag, "_en"},   {31'd0, bus.wb_en}, 32'd1);
        chk({tag, "_addr"}, {27'd0, bus.wb_addr}, {27'd0, addr});
        chk({tag, "_data"}, bus.wb_data, data);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        idle();
        tick();
        tick();

        // Reset state
        chk("rst_wb_en",     {31'd0, bus.wb_en}, 32'd0);
        chk("rst_wb_addr",   {27'd0, bus.wb_addr}, 32'd0);
        chk("rst_wb_data",   bus.wb_data, 32'd0);
        chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("rst_rs1_pend",  {31'd0, bus.rs1_pending}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU path, then x0 destination dropped with wb regs holding
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = 5'd5;
        bus.alu_result = 32'hDEADBEEF;
        tick();
        chk_wb("alu5", 5'd5, 32'hDEADBEEF);
        bus.alu_rd     = 5'd0;
        bus.alu_result = 32'h55555555;
        tick();
        chk("alu0_en",   {31'd0, bus.wb_en}, 32'd0);
        chk("alu0_addr", {27'd0, bus.wb_addr}, 32'd5);
        chk("alu0_data", bus.wb_data, 32'hDEADBEEF);
        idle();

        // Load return to x0 is accepted but never written; issue to x0 sets nothing
        bus.mem_valid      = 1'b1;
        bus.mem_rd         = 5'd0;
        bus.mem_data       = 32'hBAD0BAD0;
        bus.ld_issue_valid = 1'b1;
        bus.ld_issue_rd    = 5'd0;
        tick();
        idle();
        tick();
        chk("memx0_en",   {31'd0, bus.wb_en}, 32'd0);
        chk("issx0_pend", {31'd0, bus.rs1_pending}, 32'd0);

        // Load with scoreboard
        bus.rs1_addr = 5'd7;
        issue(5'd7);
        chk("ld7_pend_set", {31'd0, bus.rs1_pending}, 32'd1);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h12345678;
        tick();
        idle();
        chk("ld7_push_en", {31'd0, bus.wb_en}, 32'd0);
        tick();
        chk_wb("ld7", 5'd7, 32'h12345678);
        chk("ld7_pend_wb", {31'd0, bus.rs1_pending}, 32'd1);
        tick();
        chk("ld7_pend_clr", {31'd0, bus.rs1_pending}, 32'd0);
        chk("ld7_en_off",   {31'd0, bus.wb_en}, 32'd0);

        // ALU and load return in the same cycle
        bus.rs2_addr = 5'd4;
        issue(5'd4);
        chk("ld4_pend", {31'd0, bus.rs2_pending}, 32'd1);
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = 5'd3;
        bus.alu_result = 32'h1;
        bus.mem_valid  = 1'b1;
        bus.mem_rd     = 5'd4;
        bus.mem_data   = 32'h2;
        tick();
        idle();
        chk_wb("conf_alu", 5'd3, 32'h1);
        tick();
        chk_wb("conf_ld", 5'd4, 32'h2);
        tick();
        chk("conf_pend_clr", {31'd0, bus.rs2_pending}, 32'd0);

        // FIFO fill while ALU is busy every cycle
        for (int i = 0; i < 5; i++) issue(5'(8 + i));
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid  = 1'b1;
            bus.alu_rd     = 5'(20 + i);
            bus.alu_result = 32'hA0 + 32'(i);
            bus.mem_valid  = 1'b1;
            bus.mem_rd     = 5'(8 + i);
            bus.mem_data   = 32'h800 + 32'(i);
            tick();
            chk_wb($sformatf("fill_alu%0d", i), 5'(20 + i), 32'hA0 + 32'(i));
            chk($sformatf("fill_rdy%0d", i), {31'd0, bus.mem_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        // Full with ALU still busy: the held return for rd 12 is not taken
        bus.alu_rd     = 5'd24;
        bus.alu_result = 32'hA4;
        bus.mem_rd     = 5'd12;
        bus.mem_data   = 32'h80C;
        tick();
        chk_wb("full_alu", 5'd24, 32'hA4);
        chk("full_rdy_hold", {31'd0, bus.mem_ready}, 32'd0);
        // ALU drops: one pop, push still blocked because ready was low
        bus.alu_valid = 1'b0;
        tick();
        chk_wb("drain8", 5'd8, 32'h800);
        chk("drain_rdy1", {31'd0, bus.mem_ready}, 32'd1);
        // Push of rd 12 alongside pop of rd 9 keeps occupancy at 3
        tick();
        bus.mem_valid = 1'b0;
        chk_wb("drain9", 5'd9, 32'h801);
        chk("pushpop_rdy", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        chk_wb("drain10", 5'd10, 32'h802);
        tick();
        chk_wb("drain11", 5'd11, 32'h803);
        tick();
        chk_wb("drain12", 5'd12, 32'h80C);
        tick();
        chk("drain_idle", {31'd0, bus.wb_en}, 32'd0);
        bus.rs1_addr = 5'd12;
        bus.rs2_addr = 5'd8;
        chk("drain_pend12", {31'd0, bus.rs1_pending}, 32'd0);
        chk("drain_pend8",  {31'd0, bus.rs2_pending}, 32'd0);
        idle();

        // Set/clear collision on rd 9: new issue wins over load writeback clear
        bus.rs1_addr = 5'd9;
        issue(5'd9);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd9;
        bus.mem_data  = 32'h99;
        tick();
        idle();
        tick();
        chk_wb("coll_wb9", 5'd9, 32'h99);
        issue(5'd9);
        chk("coll_pend9", {31'd0, bus.rs1_pending}, 32'd1);
        tick();
        chk("coll_pend9_hold", {31'd0, bus.rs1_pending}, 32'd1);

        // Async reset mid-burst with two loads queued
        issue(5'd13);
        issue(5'd14);
        bus.rs1_addr = 5'd13;
        for (int i = 0; i < 2; i++) begin
            bus.alu_valid  = 1'b1;
            bus.alu_rd     = 5'(21 + i);
            bus.alu_result = 32'hC0 + 32'(i);
            bus.mem_valid  = 1'b1;
            bus.mem_rd     = 5'(13 + i);
            bus.mem_data   = 32'hD00 + 32'(i);
            tick();
        end
        idle();
        chk("pre_rst_en",   {31'd0, bus.wb_en}, 32'd1);
        chk("pre_rst_pend", {31'd0, bus.rs1_pending}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_en",     {31'd0, bus.wb_en}, 32'd0);
        chk("arst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        chk("arst_rs1_pend",  {31'd0, bus.rs1_pending}, 32'd0);
        chk("arst_wb_addr",   {27'd0, bus.wb_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_en%0d", i), {31'd0, bus.wb_en}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
